// File: rtl/pipe_pkg.sv
// Shared types and per-boundary widths for the pipeline stage registers.
package pipe_pkg;

  // Occupancy of a skid-buffered stage: nothing, main only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  // A bubble carries all-zero control, so every control bit reads as "do nothing".
  localparam logic CTRL_NOP_BIT = 1'b0;

  // Default payload widths for each stage boundary of the core.
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 9;
  localparam int IDEX_DATA_W  = 160;
  localparam int EXMEM_CTRL_W = 5;
  localparam int EXMEM_DATA_W = 101;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, shared by the performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  // Count up on inc, stick at all-ones, clear has priority over inc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_stage_skid.sv
// Flow-controlled pipeline stage register with a two-entry skid buffer,
// registered in_ready, synchronous flush and a saturating stall counter.
module pipeline_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W            = IDEX_CTRL_W,
  parameter int DATA_W            = IDEX_DATA_W,
  parameter bit FLUSH_CLEARS_DATA = 1'b0,
  parameter int CNT_W             = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CTRL_W-1:0] CTRL_NOP = {CTRL_W{CTRL_NOP_BIT}};

  stage_state_t      state_reg, state_next;
  logic [CTRL_W-1:0] main_ctrl_reg, main_ctrl_next;
  logic [DATA_W-1:0] main_data_reg, main_data_next;
  logic [CTRL_W-1:0] skid_ctrl_reg, skid_ctrl_next;
  logic [DATA_W-1:0] skid_data_reg, skid_data_next;
  logic              in_ready_reg, in_ready_next;

  logic in_hs;
  logic out_hs;

  assign in_hs  = in_valid && in_ready_reg;
  assign out_hs = (state_reg != EMPTY) && out_ready;

  // Next-state and storage steering; flush overrides every handshake.
  always_comb begin
    state_next     = state_reg;
    main_ctrl_next = main_ctrl_reg;
    main_data_next = main_data_reg;
    skid_ctrl_next = skid_ctrl_reg;
    skid_data_next = skid_data_reg;

    if (flush) begin
      state_next     = EMPTY;
      main_ctrl_next = CTRL_NOP;
      skid_ctrl_next = CTRL_NOP;
      if (FLUSH_CLEARS_DATA) begin
        main_data_next = '0;
        skid_data_next = '0;
      end
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_hs) begin
            state_next     = ONE;
            main_ctrl_next = in_ctrl;
            main_data_next = in_data;
          end
        end
        ONE: begin
          if (out_hs && in_hs) begin
            main_ctrl_next = in_ctrl;
            main_data_next = in_data;
          end else if (out_hs) begin
            // Draining to a bubble: control goes NOP, data is left as-is.
            state_next     = EMPTY;
            main_ctrl_next = CTRL_NOP;
          end else if (in_hs) begin
            state_next     = TWO;
            skid_ctrl_next = in_ctrl;
            skid_data_next = in_data;
          end
        end
        TWO: begin
          if (out_hs) begin
            state_next     = ONE;
            main_ctrl_next = skid_ctrl_reg;
            main_data_next = skid_data_reg;
            skid_ctrl_next = CTRL_NOP;
          end
        end
        default: begin
          state_next     = EMPTY;
          main_ctrl_next = CTRL_NOP;
          skid_ctrl_next = CTRL_NOP;
        end
      endcase
    end

    // Only a full skid buffer blocks upstream; decided from next state so it is registered.
    in_ready_next = (state_next != TWO);
  end

  // State and payload registers; reset empties the stage and zeroes all payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= EMPTY;
      main_ctrl_reg <= CTRL_NOP;
      main_data_reg <= '0;
      skid_ctrl_reg <= CTRL_NOP;
      skid_data_reg <= '0;
      in_ready_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      main_ctrl_reg <= main_ctrl_next;
      main_data_reg <= main_data_next;
      skid_ctrl_reg <= skid_ctrl_next;
      skid_data_reg <= skid_data_next;
      in_ready_reg  <= in_ready_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg != EMPTY);
  assign out_ctrl  = main_ctrl_reg;
  assign out_data  = main_data_reg;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid && !out_ready),
    .clear (1'b0),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Bench for pipeline_stage_skid: directed sequences plus a random stream,
// checked by a scoreboard queue that a negedge monitor drains.
module tb_pipeline_stage_skid;

  localparam int CTRL_W = 9;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = 15;

  typedef struct {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } entry_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic [CNT_W-1:0]  stall_cnt;

  int errors = 0;
  int checks = 0;
  int stall_exp = 0;
  entry_t exp_q[$];

  pipeline_stage_skid #(
    .CTRL_W            (CTRL_W),
    .DATA_W            (DATA_W),
    .FLUSH_CLEARS_DATA (1'b1),
    .CNT_W             (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .flush     (flush),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int tag);
    in_valid = v;
    in_ctrl  = CTRL_W'(tag);
    in_data  = 32'hD000_0000 + DATA_W'(tag);
  endtask

  // Monitor: inputs and outputs are stable at the negedge; compare what is
  // shown now, then book what the coming posedge will accept or deliver.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_exp = 0;
    end
    chk("stall_cnt", stall_cnt, stall_exp);
    if (!out_valid) begin
      chk("bubble_ctrl_nop", out_ctrl, 0);
    end else if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_output: got ctrl 0x%0h data 0x%0h expected nothing at %0t",
               out_ctrl, out_data, $time);
    end else begin
      chk("out_ctrl", out_ctrl, exp_q[0].c);
      chk("out_data", out_data, exp_q[0].d);
    end
    if (!rst) begin
      if (out_valid && !out_ready && stall_exp < CNT_MAX) stall_exp++;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (in_valid && in_ready) exp_q.push_back('{c: in_ctrl, d: in_data});
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    out_ready = 1'b0; flush = 1'b0;

    // Reset values.
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    rst = 1'b0;
    tick();

    // Stream 1..8 with downstream always ready: one per cycle, one cycle late.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("stream_in_ready", in_ready, 1);
      drive(1'b1, i);
      tick();
      chk("stream_out_valid", out_valid, 1);
      chk("stream_out_ctrl", out_ctrl, i);
    end
    drive(1'b0, 0);
    tick();
    chk("stream_drained", out_valid, 0);
    chk("stream_stall_cnt", stall_cnt, 0);

    // Skid fill: 0xA in main, 0xB into skid, three stalled cycles.
    out_ready = 1'b0;
    drive(1'b1, 'hA);
    tick();
    chk("skid_main_a", out_ctrl, 'hA);
    chk("skid_ready_one", in_ready, 1);
    drive(1'b1, 'hB);
    tick();
    chk("skid_ready_two", in_ready, 0);
    chk("skid_still_a", out_ctrl, 'hA);
    drive(1'b0, 0);
    tick(); tick();
    chk("skid_stall_3", stall_cnt, 3);
    out_ready = 1'b1;
    tick();
    chk("skid_deliver_b", out_ctrl, 'hB);
    chk("skid_ready_back", in_ready, 1);
    tick();
    chk("skid_empty", out_valid, 0);
    chk("skid_stall_final", stall_cnt, 3);

    // Flush in TWO with 0xC presented: nothing survives.
    out_ready = 1'b0;
    drive(1'b1, 'hA); tick();
    drive(1'b1, 'hB); tick();
    chk("flush_two_ready", in_ready, 0);
    drive(1'b1, 'hC); flush = 1'b1;
    tick();
    flush = 1'b0; drive(1'b0, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_ctrl", out_ctrl, 0);
    chk("flush_out_data", out_data, 0);
    chk("flush_in_ready", in_ready, 1);

    // Flush in ONE while an input handshake is offered: the input is dropped.
    drive(1'b1, 'hA); tick();
    drive(1'b1, 'hC); flush = 1'b1;
    tick();
    flush = 1'b0; drive(1'b0, 0);
    chk("flush_one_out_valid", out_valid, 0);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("flush_stays_empty", out_valid, 0);

    // Counter saturation at 15 and immunity to flush.
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 'hD); tick();
    drive(1'b0, 0);
    repeat (20) tick();
    chk("sat_stall_15", stall_cnt, 15);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("sat_after_flush", stall_cnt, 15);
    chk("sat_flush_empty", out_valid, 0);

    // Asynchronous reset mid-stream.
    out_ready = 1'b1;
    for (int i = 'h20; i < 'h24; i++) begin
      drive(1'b1, i);
      tick();
    end
    drive(1'b1, 'h24);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_ctrl", out_ctrl, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    tick();
    rst = 1'b0;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_still_empty", out_valid, 0);
    for (int i = 'h30; i < 'h34; i++) begin
      drive(1'b1, i);
      tick();
    end
    drive(1'b0, 0);
    tick(); tick();

    // Random valid/ready traffic; the monitor checks order and bubble control.
    for (int n = 0; n < 10000; n++) begin
      drive($urandom_range(0, 3) != 0, (n % 511) + 1);
      in_data = 32'h5000_0000 + n;
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    // Drain and confirm nothing was lost.
    drive(1'b0, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    tick();
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_out_valid", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
